fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage and IF/ID pipeline register for the 5-stage KLP32 core. Owns the PC, issues one-outstanding requests to instruction memory, and presents fetched instructions to decode (ID). Consumes the hazard unit's `stall` and the execute stage's branch/jump redirect. Inserts NOP bubbles on redirect.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC fetched first after reset.
- `XLEN`, 32, address/instruction width. Only 32 is supported.

Ports:
- `CLK`  in  1  core clock; all state on rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `STALL`  in  1  hazard-unit stall; hold the IF/ID register and do not advance the PC.
- `REDIRECT`  in  1  taken branch/jump from IX; flush and refetch.
- `REDIRECT_PC`  in  32  redirect target; valid when `REDIRECT`=1.
- `IMEM_REQ`  out  1  fetch request.
- `IMEM_ADDR`  out  32  fetch address; stable while `IMEM_REQ`=1 and `IMEM_GNT`=0.
- `IMEM_GNT`  in  1  request accepted this cycle.
- `IMEM_RVALID`  in  1  response valid; at least 1 cycle after grant.
- `IMEM_RDATA`  in  32  instruction word.
- `ID_VALID`  out  1  IF/ID holds a real instruction.
- `ID_PC`  out  32  PC of the ID instruction.
- `ID_INSTR`  out  32  instruction; NOP (32'h0000_0013) when `ID_VALID`=0.

## Operation
- FSM states:
  - ISSUE: `IMEM_REQ`=1, `IMEM_ADDR`=PC.
    - `IMEM_GNT` → WAIT.
  - WAIT: one request outstanding.
    - `IMEM_RVALID` → ISSUE.
  - DISCARD: the outstanding response belongs to a flushed path.
    - `IMEM_RVALID` → ISSUE, and the data is dropped.
- PC advances by 4 on grant, 32-bit wrap (32'hFFFF_FFFC → 0).
- Response while `STALL`=0 and hold buffer empty: load `ID_VALID`=1, `ID_PC`=fetched PC, `ID_INSTR`=`IMEM_RDATA`.
- Response while `STALL`=1: capture into a 1-entry hold buffer (PC+instr).
  - IF/ID is unchanged.
  - ISSUE keeps `IMEM_REQ`=0 while the buffer is full.
- Buffer full and `STALL`=0: buffer moves to IF/ID; buffer empties.
- No response and `STALL`=0: IF/ID loads a bubble (`ID_VALID`=0, NOP).
- `STALL`=1: IF/ID holds its value.
- `REDIRECT`=1 takes priority over `STALL`:
  - PC ← `REDIRECT_PC`.
  - IF/ID ← bubble.
  - Hold buffer cleared.
  - In WAIT without `IMEM_RVALID`, or in ISSUE with `IMEM_GNT`: next state DISCARD.
  - In WAIT with `IMEM_RVALID`: response dropped; next state ISSUE.
  - In DISCARD: stays in DISCARD.
- `REDIRECT_PC[1:0]` is ignored (forced to 0).

## Timing
- Reset values:
  - state=ISSUE, PC=`RESET_PC`, hold buffer empty.
  - `ID_VALID`=0, `ID_PC`=0, `ID_INSTR`=NOP.
  - `IMEM_REQ`=0 during the reset cycle, 1 from the first cycle after `RST` falls.
- `IMEM_REQ`/`IMEM_ADDR` are combinational from state/PC only. No path from `IMEM_GNT`/`IMEM_RVALID`.
- Latency from `IMEM_RVALID` (no stall) to `ID_VALID`: 1 edge.
- Throughput: 1 instruction per 2 cycles with 1-cycle memory, because the next request goes out the cycle after a response.
- `RST` in any state, including DISCARD with a pending response, returns all state to reset values. A response arriving later is ignored: it is only honoured in WAIT/DISCARD, and the first request after reset is ISSUE.

## Configuration
- `FETCH_PERF_EN` defined: adds two 32-bit wrapping counters and output ports `PERF_FETCHED` and `PERF_STALLS`.
  - `PERF_FETCHED` increments per IF/ID load with `ID_VALID`=1.
  - `PERF_STALLS` increments per cycle with `STALL`=1.
  - Both are cleared by `RST`.
- Undefined: counters and ports are absent; behaviour is otherwise identical.

## Structure
- Shared package `klp32_pkg`:
  - `NOP_INSTR` (32'h0000_0013).
  - `fetch_state_t` enum (ISSUE, WAIT, DISCARD).
  - `XLEN` constant.
- Sub-module `fetch_hold_buf`: 1-entry PC+instr buffer with `load`/`drain`/`clear`, instantiated once.
- PC/FSM and the IF/ID register stay in `fetch_stage`.

## Test plan
- Reset, then 1-cycle-latency memory returning addr+1:
  - `IMEM_ADDR` = 0, 4, 8.
  - `ID_INSTR` = 1, 5, 9 with `ID_VALID`=1 on alternating cycles.
- `STALL`=1 for 3 cycles while the response for PC 8 arrives:
  - `ID_PC` holds 4 for 3 cycles; `IMEM_REQ`=0.
  - After release: `ID_PC`=8, then a request for 12.
- `REDIRECT`=1 to 32'h100 while WAIT (no `RVALID`):
  - The next `RVALID` is dropped; `ID_VALID`=0 until the 0x100 instruction appears.
  - `IMEM_ADDR`=0x100.
- `REDIRECT` and `STALL` together:
  - IF/ID becomes a NOP bubble; PC=target.
- PC wrap:
  - `REDIRECT_PC`=32'hFFFF_FFFC gives fetch addresses FFFF_FFFC then 0000_0000.
- `RST` asserted in DISCARD, with `RVALID` in the cycle after release:
  - `ID_VALID` stays 0; the first fetch is `RESET_PC`.

Source files
------------

// File: rtl/klp32_pkg.sv
// klp32_pkg: shared constants and types for the KLP32 core.
// Exports XLEN, NOP_INSTR, fetch_state_t and the IF/ID bundle if_id_t.
package klp32_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ISSUE   = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response bus.
// master = fetch side (REQ/ADDR out), slave = memory side (GNT/RVALID/RDATA out).
interface fetch_stage_if;
  import klp32_pkg::*;

  logic            IMEM_REQ;
  logic [XLEN-1:0] IMEM_ADDR;
  logic            IMEM_GNT;
  logic            IMEM_RVALID;
  logic [XLEN-1:0] IMEM_RDATA;

  modport master (
    output IMEM_REQ,
    output IMEM_ADDR,
    input  IMEM_GNT,
    input  IMEM_RVALID,
    input  IMEM_RDATA
  );

  modport slave (
    input  IMEM_REQ,
    input  IMEM_ADDR,
    output IMEM_GNT,
    output IMEM_RVALID,
    output IMEM_RDATA
  );

endinterface

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: 1-entry PC+instr buffer for responses that land during a stall.
// Ports: clk, rst, load/drain/clear controls, in_pc/in_instr, full, out_pc/out_instr.
module fetch_hold_buf
  import klp32_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            drain,
  input  logic            clear,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_instr,
  output logic            full,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr
);

  logic            full_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;

  // clear beats load: a flushed response must never be kept
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      full_q  <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
    end else if (load) begin
      full_q  <= 1'b1;
      pc_q    <= in_pc;
      instr_q <= in_instr;
    end else if (drain) begin
      full_q  <= 1'b0;
    end
  end

  assign full      = full_q;
  assign out_pc    = pc_q;
  assign out_instr = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: KLP32 PC, one-outstanding imem fetch FSM and IF/ID register.
// Ports: CLK, RST (sync, high), STALL, REDIRECT/REDIRECT_PC, imem (fetch_stage_if.master),
// ID_VALID/ID_PC/ID_INSTR. FETCH_PERF_EN adds PERF_FETCHED and PERF_STALLS.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              STALL,
  input  logic              REDIRECT,
  input  logic [XLEN-1:0]   REDIRECT_PC,
  fetch_stage_if.master     imem,
  output logic              ID_VALID,
  output logic [XLEN-1:0]   ID_PC,
  output logic [XLEN-1:0]   ID_INSTR
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       PERF_FETCHED,
  output logic [31:0]       PERF_STALLS
`endif
);
  import klp32_pkg::*;

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  if_id_t          if_id;

  logic            hold_full;
  logic [XLEN-1:0] hold_pc;
  logic [XLEN-1:0] hold_instr;

  logic            grant;
  logic            resp;
  logic            hold_load;
  logic            hold_drain;
  logic [XLEN-1:0] target;
  logic            redirect_pc_unused;

  // instruction alignment: low target bits carry no meaning
  assign target             = {REDIRECT_PC[XLEN-1:2], 2'b00};
  assign redirect_pc_unused = ^REDIRECT_PC[1:0];

  // request depends on registered state only, never on GNT/RVALID
  assign imem.IMEM_REQ  = !RST && (state == ISSUE) && !hold_full;
  assign imem.IMEM_ADDR = pc;

  assign grant = imem.IMEM_REQ && imem.IMEM_GNT;
  assign resp  = (state == WAIT) && imem.IMEM_RVALID;

  assign hold_load  = resp && STALL && !REDIRECT;
  assign hold_drain = hold_full && !STALL && !REDIRECT;

  fetch_hold_buf u_hold (
    .clk       (CLK),
    .rst       (RST),
    .load      (hold_load),
    .drain     (hold_drain),
    .clear     (REDIRECT),
    .in_pc     (req_pc),
    .in_instr  (imem.IMEM_RDATA),
    .full      (hold_full),
    .out_pc    (hold_pc),
    .out_instr (hold_instr)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= ISSUE;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
    end else begin
      unique case (state)
        ISSUE: begin
          if (grant)
            state <= REDIRECT ? DISCARD : WAIT;
        end
        WAIT: begin
          if (imem.IMEM_RVALID)
            state <= ISSUE;
          else if (REDIRECT)
            state <= DISCARD;
        end
        // a new redirect adds no request: only the one stale
        // response is still owed, so its arrival ends DISCARD
        DISCARD: begin
          if (imem.IMEM_RVALID)
            state <= ISSUE;
        end
        default: state <= ISSUE;
      endcase

      if (grant)
        req_pc <= pc;

      if (REDIRECT)
        pc <= target;
      else if (grant)
        pc <= pc + XLEN'(4);
    end
  end

  // bubble keeps ID_PC so decode sees a stable PC across stalls
  always_ff @(posedge CLK) begin
    if (RST) begin
      if_id.valid <= 1'b0;
      if_id.pc    <= '0;
      if_id.instr <= NOP_INSTR;
    end else if (REDIRECT) begin
      if_id.valid <= 1'b0;
      if_id.instr <= NOP_INSTR;
    end else if (!STALL) begin
      unique case (1'b1)
        hold_full: begin
          if_id.valid <= 1'b1;
          if_id.pc    <= hold_pc;
          if_id.instr <= hold_instr;
        end
        resp: begin
          if_id.valid <= 1'b1;
          if_id.pc    <= req_pc;
          if_id.instr <= imem.IMEM_RDATA;
        end
        default: begin
          if_id.valid <= 1'b0;
          if_id.instr <= NOP_INSTR;
        end
      endcase
    end
  end

  assign ID_VALID = if_id.valid;
  assign ID_PC    = if_id.pc;
  assign ID_INSTR = if_id.instr;

`ifdef FETCH_PERF_EN
  logic        id_load_valid;
  logic [31:0] fetched_q;
  logic [31:0] stalls_q;

  assign id_load_valid = !REDIRECT && !STALL
                      && (hold_full || resp);

  always_ff @(posedge CLK) begin
    if (RST) begin
      fetched_q <= '0;
      stalls_q  <= '0;
    end else begin
      if (id_load_valid)
        fetched_q <= fetched_q + 32'd1;
      if (STALL)
        stalls_q <= stalls_q + 32'd1;
    end
  end

  assign PERF_FETCHED = fetched_q;
  assign PERF_STALLS  = stalls_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage with a 1-cycle memory.
// Granted fetches are queued as {pc, pc+1} and popped when IF/ID loads.
module tb_fetch_stage;
  import klp32_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stalls;
`endif

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .CLK         (clk),
    .RST         (rst),
    .STALL       (stall),
    .REDIRECT    (redirect),
    .REDIRECT_PC (redirect_pc),
    .imem        (bus),
    .ID_VALID    (id_valid),
    .ID_PC       (id_pc),
    .ID_INSTR    (id_instr)
`ifdef FETCH_PERF_EN
    ,
    .PERF_FETCHED(perf_fetched),
    .PERF_STALLS (perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  exp_t        q[$];
  bit          pend = 0;
  logic [31:0] pend_addr = '0;
  bit          live = 0;
  int          arrived = 0;
  int          loads = 0;
  logic [31:0] exp_pc = RST_PC;
  logic [31:0] exp_id_pc = '0;
  logic        exp_id_v = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // one clock: drive at negedge, memory grants every request and
  // answers the cycle after (rv_en=0 holds the answer back)
  task automatic step(input logic s, input logic r,
                      input logic [31:0] rp, input bit rv_en);
    logic        granted;
    logic        rv_del;
    logic        exp_v;
    logic [31:0] gaddr;
    exp_t        e;
    @(negedge clk);
    stall       = s;
    redirect    = r;
    redirect_pc = rp;
    rv_del      = pend && rv_en;
    bus.IMEM_RVALID = rv_del;
    bus.IMEM_RDATA  = rv_del ? pend_addr + 32'd1 : 32'hDEAD_BEEF;
    bus.IMEM_GNT    = bus.IMEM_REQ;
    granted = bus.IMEM_REQ;
    gaddr   = bus.IMEM_ADDR;
    if (rst)
      chk("req_in_rst", 32'(bus.IMEM_REQ), 32'd0);
    else if (arrived > 0)
      chk("req_blocked", 32'(bus.IMEM_REQ), 32'd0);
    if (granted)
      chk("fetch_addr", gaddr, exp_pc);
    @(posedge clk);
    #1;
    if (rv_del) pend = 0;
    if (granted) begin
      pend      = 1;
      pend_addr = gaddr;
    end
    if (rst) begin
      q.delete();
      live    = 0;
      arrived = 0;
      exp_pc  = RST_PC;
      chk("rst_valid", 32'(id_valid), 32'd0);
      chk("rst_pc", id_pc, 32'd0);
      chk("rst_instr", id_instr, NOP_INSTR);
      exp_id_v  = 1'b0;
      exp_id_pc = '0;
    end else if (r) begin
      q.delete();
      live    = 0;
      arrived = 0;
      exp_pc  = {rp[31:2], 2'b00};
      chk("flush_valid", 32'(id_valid), 32'd0);
      chk("flush_nop", id_instr, NOP_INSTR);
      exp_id_v = 1'b0;
    end else begin
      if (rv_del && live) begin
        arrived++;
        live = 0;
      end
      if (granted) begin
        q.push_back('{gaddr, gaddr + 32'd1});
        live   = 1;
        exp_pc = gaddr + 32'd4;
      end
      if (s) begin
        chk("hold_valid", 32'(id_valid), 32'(exp_id_v));
        chk("hold_pc", id_pc, exp_id_pc);
      end else begin
        exp_v = (arrived > 0);
        chk("id_valid", 32'(id_valid), 32'(exp_v));
        if (exp_v && q.size() > 0) begin
          e = q.pop_front();
          arrived--;
          loads++;
          chk("id_pc", id_pc, e.pc);
          chk("id_instr", id_instr, e.instr);
          exp_id_pc = e.pc;
        end else begin
          chk("bubble_nop", id_instr, NOP_INSTR);
        end
        exp_id_v = exp_v;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    bus.IMEM_GNT = 1'b0;
    bus.IMEM_RVALID = 1'b0;
    bus.IMEM_RDATA = '0;

    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    rst = 1'b0;

    // 0, 4 fetched; 8 granted
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
    chk("alt_rate", 32'(loads), 32'd2);

    // response for 8 lands under a 3-cycle stall
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("after_stall_pc", id_pc, 32'h8);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // redirect while WAIT, response held back
    step(0, 0, 0, 1);
    step(0, 1, 32'h100, 0);
    step(0, 0, 0, 1);
    chk("redir_addr", bus.IMEM_ADDR, 32'h100);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // redirect together with stall and a live response
    step(0, 0, 0, 1);
    step(1, 1, 32'h202, 1);
    chk("redir_stall_pc", bus.IMEM_ADDR, 32'h200);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // wrap, redirect in ISSUE with grant
    step(0, 1, 32'hFFFF_FFFC, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("wrap_addr", bus.IMEM_ADDR, 32'h0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);

    // reset while DISCARD, stale response after release
    step(0, 0, 0, 1);
    step(0, 1, 32'h300, 0);
    rst = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst = 1'b0;
    step(0, 0, 0, 1);
    chk("post_rst_valid", 32'(id_valid), 32'd0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    chk("post_rst_pc", id_pc, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
